// File: rtl/fibo_seq_ctrl.sv
// fibo_seq_ctrl -- Moore sequencer for the Fibonacci register-file datapath.
//
// On Start it loads the iteration count N from memory into R2, clears R0 (a)
// and sets R1 (b) to 1, and then loops N times computing
//   R3 <= a+b ; R0 <= b ; R1 <= R3 ; R2 <= R2-1
// until the counter reads zero. It then pulses Done for one cycle. F(N) is left
// in R0, modulo 2^(SIZE+1).
//
// Ports
//   Clk        : system clock, rising edge
//   Rst        : asynchronous active-low reset
//   Start      : run request, sampled only in IDLE
//   zero_flag  : datapath ALU result == 0 (combinational)
//   wrt_addr   : RF write address
//   wrt_en     : RF write enable (write happens at the next rising edge)
//   load_data  : 1 = RF write data comes from the memory count, 0 = from the ALU
//   rd_addr1   : RF read port 1 address
//   rd_addr2   : RF read port 2 address
//   alu_opcode : ALU operation
//   Busy       : high in every state except IDLE
//   Done       : one-cycle completion pulse
module fibo_seq_ctrl #(
  parameter int              SIZE    = 3,
  parameter logic [SIZE-1:0] OP_ADD  = 3'b000,
  parameter logic [SIZE-1:0] OP_SUB  = 3'b001,
  parameter logic [SIZE-1:0] OP_PASS = 3'b010,
  parameter logic [SIZE-1:0] OP_INC  = 3'b011,
  parameter logic [SIZE-1:0] OP_DEC  = 3'b100
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic            zero_flag,
  output logic [SIZE-2:0] wrt_addr,
  output logic            wrt_en,
  output logic            load_data,
  output logic [SIZE-2:0] rd_addr1,
  output logic [SIZE-2:0] rd_addr2,
  output logic [SIZE-1:0] alu_opcode,
  output logic            Busy,
  output logic            Done
);

  // Register-file map
  localparam logic [SIZE-2:0] R_A   = (SIZE-1)'(0);  // a, final result
  localparam logic [SIZE-2:0] R_B   = (SIZE-1)'(1);  // b
  localparam logic [SIZE-2:0] R_CNT = (SIZE-1)'(2);  // loop counter
  localparam logic [SIZE-2:0] R_TMP = (SIZE-1)'(3);  // a+b scratch

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_CLR  = 4'd2,
    S_SETB = 4'd3,
    S_TEST = 4'd4,
    S_ADD  = 4'd5,
    S_MOVA = 4'd6,
    S_MOVB = 4'd7,
    S_DEC  = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Outputs depend on r_state alone; Start and zero_flag only steer w_next.
  always_comb begin
    w_next     = S_IDLE;
    wrt_addr   = R_A;
    wrt_en     = 1'b0;
    load_data  = 1'b0;
    rd_addr1   = R_A;
    rd_addr2   = R_A;
    alu_opcode = OP_PASS;
    Busy       = 1'b1;
    Done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        Busy   = 1'b0;
        w_next = Start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        wrt_addr  = R_CNT;
        wrt_en    = 1'b1;
        load_data = 1'b1;
        w_next    = S_CLR;
      end
      S_CLR: begin
        // a <= a - a clears R0 without a dedicated zero opcode
        rd_addr1   = R_A;
        rd_addr2   = R_A;
        alu_opcode = OP_SUB;
        wrt_addr   = R_A;
        wrt_en     = 1'b1;
        w_next     = S_SETB;
      end
      S_SETB: begin
        // R0 is already 0, so 0+1 seeds b
        rd_addr1   = R_A;
        alu_opcode = OP_INC;
        wrt_addr   = R_B;
        wrt_en     = 1'b1;
        w_next     = S_TEST;
      end
      S_TEST: begin
        // Pass the counter through the ALU so zero_flag reflects it
        rd_addr1   = R_CNT;
        alu_opcode = OP_PASS;
        w_next     = zero_flag ? S_DONE : S_ADD;
      end
      S_ADD: begin
        rd_addr1   = R_A;
        rd_addr2   = R_B;
        alu_opcode = OP_ADD;
        wrt_addr   = R_TMP;
        wrt_en     = 1'b1;
        w_next     = S_MOVA;
      end
      S_MOVA: begin
        rd_addr1   = R_B;
        alu_opcode = OP_PASS;
        wrt_addr   = R_A;
        wrt_en     = 1'b1;
        w_next     = S_MOVB;
      end
      S_MOVB: begin
        rd_addr1   = R_TMP;
        alu_opcode = OP_PASS;
        wrt_addr   = R_B;
        wrt_en     = 1'b1;
        w_next     = S_DEC;
      end
      S_DEC: begin
        rd_addr1   = R_CNT;
        alu_opcode = OP_DEC;
        wrt_addr   = R_CNT;
        wrt_en     = 1'b1;
        w_next     = S_TEST;
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        // Unreachable encodings fall back to IDLE with quiet outputs
        Busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Directed testbench for fibo_seq_ctrl. Includes a behavioural model of the
// 4-entry register file and ALU so the controller sees a real zero_flag.
module tb_fibo_seq_ctrl;

  logic       Clk;
  logic       Rst;
  logic       Start;
  logic       zero_flag;
  logic [1:0] wrt_addr;
  logic       wrt_en;
  logic       load_data;
  logic [1:0] rd_addr1;
  logic [1:0] rd_addr2;
  logic [2:0] alu_opcode;
  logic       Busy;
  logic       Done;

  fibo_seq_ctrl #(.SIZE(3)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .zero_flag(zero_flag),
    .wrt_addr(wrt_addr), .wrt_en(wrt_en), .load_data(load_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .alu_opcode(alu_opcode),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Datapath model
  logic [3:0] mem_count;
  logic [3:0] rf [4];
  logic [3:0] alu;

  always_comb begin
    alu = rf[rd_addr1];
    case (alu_opcode)
      3'b000:  alu = rf[rd_addr1] + rf[rd_addr2];
      3'b001:  alu = rf[rd_addr1] - rf[rd_addr2];
      3'b010:  alu = rf[rd_addr1];
      3'b011:  alu = rf[rd_addr1] + 4'd1;
      3'b100:  alu = rf[rd_addr1] - 4'd1;
      default: alu = rf[rd_addr1];
    endcase
  end
  assign zero_flag = (alu == 4'd0);

  always @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
    end else if (wrt_en) begin
      rf[wrt_addr] <= load_data ? mem_count : alu;
    end
  end

  // Observed output vector: {wa, we, ld, rd1, rd2, op, busy, done}
  logic [12:0] obs;
  assign obs = {wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode, Busy, Done};

  localparam logic [12:0] V_IDLE = {2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b010, 1'b0, 1'b0};
  localparam logic [12:0] V_LOAD = {2'd2, 1'b1, 1'b1, 2'd0, 2'd0, 3'b010, 1'b1, 1'b0};
  localparam logic [12:0] V_CLR  = {2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 1'b1, 1'b0};
  localparam logic [12:0] V_SETB = {2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 3'b011, 1'b1, 1'b0};
  localparam logic [12:0] V_TEST = {2'd0, 1'b0, 1'b0, 2'd2, 2'd0, 3'b010, 1'b1, 1'b0};
  localparam logic [12:0] V_ADD  = {2'd3, 1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 1'b1, 1'b0};
  localparam logic [12:0] V_MOVA = {2'd0, 1'b1, 1'b0, 2'd1, 2'd0, 3'b010, 1'b1, 1'b0};
  localparam logic [12:0] V_MOVB = {2'd1, 1'b1, 1'b0, 2'd3, 2'd0, 3'b010, 1'b1, 1'b0};
  localparam logic [12:0] V_DEC  = {2'd2, 1'b1, 1'b0, 2'd2, 2'd0, 3'b100, 1'b1, 1'b0};
  localparam logic [12:0] V_DONE = {2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b010, 1'b1, 1'b1};

  // Expected outputs in cycle k after the Start-sampling edge for count n
  function automatic logic [12:0] exp_vec(input int k, input int n);
    if (k < 1 || k > 5 + 5*n) return V_IDLE;
    if (k == 1) return V_LOAD;
    if (k == 2) return V_CLR;
    if (k == 3) return V_SETB;
    if (k == 5 + 5*n) return V_DONE;
    case ((k - 4) % 5)
      0: return V_TEST;
      1: return V_ADD;
      2: return V_MOVA;
      3: return V_MOVB;
      default: return V_DEC;
    endcase
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  int          done_at[$];
  logic [3:0]  r0_at[$];
  logic [12:0] trace[$];
  int          busy_n;

  // Launch one run and record what happens for ncyc cycles after edge 0.
  task automatic run(input logic [3:0] cnt, input bit hold, input int pulse_at, input int ncyc);
    done_at.delete(); r0_at.delete(); trace.delete(); busy_n = 0;
    @(negedge Clk);
    mem_count = cnt;
    Start = 1'b1;
    @(posedge Clk);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge Clk);
      trace.push_back(obs);
      if (Busy) busy_n++;
      if (Done) begin
        done_at.push_back(k);
        r0_at.push_back(rf[0]);
      end
      Start = hold || (k == pulse_at);
    end
    Start = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset;
    int dn, bn;
    Rst = 1'b0; Start = 1'b0; mem_count = 4'd5;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (obs !== V_IDLE) begin n_bad++; $display("FAIL reset_state got=%b exp=%b", obs, V_IDLE); end
    Rst = 1'b1;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (obs !== V_LOAD) begin n_bad++; $display("FAIL reset_inload got=%b exp=%b", obs, V_LOAD); end
    #2 Rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_IDLE) begin n_bad++; $display("FAIL reset_async got=%b exp=%b", obs, V_IDLE); end
    repeat (2) @(negedge Clk);
    n_cmp++;
    if (obs !== V_IDLE) begin n_bad++; $display("FAIL reset_held got=%b exp=%b", obs, V_IDLE); end
    Start = 1'b0;
    Rst = 1'b1;
    dn = 0; bn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (Done) dn++;
      if (Busy) bn++;
    end
    n_cmp++;
    if (dn !== 0) begin n_bad++; $display("FAIL reset_nodone got=%0d exp=0", dn); end
    n_cmp++;
    if (bn !== 0) begin n_bad++; $display("FAIL reset_idle busy_cycles got=%0d exp=0", bn); end
  endtask

  task automatic test_zero;
    run(4'd0, 1'b0, 0, 10);
    n_cmp++;
    if (done_at.size() !== 1) begin n_bad++; $display("FAIL zero_ndone got=%0d exp=1", done_at.size()); end
    n_cmp++;
    if ((done_at.size() > 0 ? done_at[0] : -1) !== 5) begin
      n_bad++; $display("FAIL zero_latency got=%0d exp=5", done_at.size() > 0 ? done_at[0] : -1);
    end
    n_cmp++;
    if (busy_n !== 5) begin n_bad++; $display("FAIL zero_busy got=%0d exp=5", busy_n); end
    n_cmp++;
    if ((r0_at.size() > 0 ? r0_at[0] : 4'hx) !== 4'd0) begin
      n_bad++; $display("FAIL zero_r0 got=%0d exp=0", r0_at.size() > 0 ? r0_at[0] : 4'hx);
    end
  endtask

  task automatic test_trace;
    run(4'd3, 1'b0, 0, 26);
    n_cmp++;
    if ((done_at.size() > 0 ? done_at[0] : -1) !== 20) begin
      n_bad++; $display("FAIL n3_latency got=%0d exp=20", done_at.size() > 0 ? done_at[0] : -1);
    end
    n_cmp++;
    if ((r0_at.size() > 0 ? r0_at[0] : 4'hx) !== 4'd2) begin
      n_bad++; $display("FAIL n3_r0 got=%0d exp=2", r0_at.size() > 0 ? r0_at[0] : 4'hx);
    end
    for (int k = 1; k <= 26; k++) begin
      n_cmp++;
      if (trace[k-1] !== exp_vec(k, 3)) begin
        n_bad++; $display("FAIL n3_trace cycle=%0d got=%b exp=%b", k, trace[k-1], exp_vec(k, 3));
      end
    end
  endtask

  task automatic test_ignore_start;
    run(4'd7, 1'b0, 10, 45);
    n_cmp++;
    if (done_at.size() !== 1) begin n_bad++; $display("FAIL n7_ndone got=%0d exp=1", done_at.size()); end
    n_cmp++;
    if ((done_at.size() > 0 ? done_at[0] : -1) !== 40) begin
      n_bad++; $display("FAIL n7_latency got=%0d exp=40", done_at.size() > 0 ? done_at[0] : -1);
    end
    n_cmp++;
    if ((r0_at.size() > 0 ? r0_at[0] : 4'hx) !== 4'd13) begin
      n_bad++; $display("FAIL n7_r0 got=%0d exp=13", r0_at.size() > 0 ? r0_at[0] : 4'hx);
    end
    n_cmp++;
    if (busy_n !== 40) begin n_bad++; $display("FAIL n7_busy got=%0d exp=40", busy_n); end
  endtask

  task automatic test_wrap;
    run(4'd15, 1'b0, 0, 85);
    n_cmp++;
    if ((done_at.size() > 0 ? done_at[0] : -1) !== 80) begin
      n_bad++; $display("FAIL n15_latency got=%0d exp=80", done_at.size() > 0 ? done_at[0] : -1);
    end
    n_cmp++;
    if ((r0_at.size() > 0 ? r0_at[0] : 4'hx) !== 4'd2) begin
      n_bad++; $display("FAIL n15_r0 got=%0d exp=2", r0_at.size() > 0 ? r0_at[0] : 4'hx);
    end
  endtask

  task automatic test_back_to_back;
    run(4'd1, 1'b1, 0, 22);
    n_cmp++;
    if (done_at.size() !== 2) begin n_bad++; $display("FAIL b2b_ndone got=%0d exp=2", done_at.size()); end
    n_cmp++;
    if ((done_at.size() > 0 ? done_at[0] : -1) !== 10) begin
      n_bad++; $display("FAIL b2b_first got=%0d exp=10", done_at.size() > 0 ? done_at[0] : -1);
    end
    n_cmp++;
    if ((done_at.size() > 1 ? done_at[1] : -1) !== 21) begin
      n_bad++; $display("FAIL b2b_second got=%0d exp=21", done_at.size() > 1 ? done_at[1] : -1);
    end
    n_cmp++;
    if ((r0_at.size() > 0 ? r0_at[0] : 4'hx) !== 4'd1) begin
      n_bad++; $display("FAIL b2b_r0_first got=%0d exp=1", r0_at.size() > 0 ? r0_at[0] : 4'hx);
    end
    n_cmp++;
    if ((r0_at.size() > 1 ? r0_at[1] : 4'hx) !== 4'd1) begin
      n_bad++; $display("FAIL b2b_r0_second got=%0d exp=1", r0_at.size() > 1 ? r0_at[1] : 4'hx);
    end
    n_cmp++;
    if (trace[10] !== V_IDLE) begin
      n_bad++; $display("FAIL b2b_gap cycle=11 got=%b exp=%b", trace[10], V_IDLE);
    end
    n_cmp++;
    if (trace[11] !== V_LOAD) begin
      n_bad++; $display("FAIL b2b_restart cycle=12 got=%b exp=%b", trace[11], V_LOAD);
    end
  endtask

  initial begin
    Rst = 1'b0;
    Start = 1'b0;
    mem_count = 4'd0;
    test_reset();
    test_zero();
    test_trace();
    test_ignore_start();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
